// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - handshake bundle between two pipeline stages through a skid stage
interface pipe_stage_skid_if #(
    parameter int DATA_W = 40
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );

endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready handshake and 2-entry skid
module pipe_stage_skid #(
    parameter int                DATA_W  = 40,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter bit                SKID    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_skid_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic              in_ready;
    logic              push;
    logic              pop;

    // With the skid entry present, in_ready comes straight from a flop so
    // out_ready never reaches upstream combinationally.
    assign in_ready = SKID ? in_ready_q : (!out_valid_q || bus.out_ready);
    assign push     = bus.in_valid && in_ready;
    assign pop      = out_valid_q && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Accepted/consumed beats this cycle still count; held data is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (push && SKID) begin
                        state_d = ST_TWO;
                        skid_d  = bus.in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid in skid and single-entry builds
module tb_pipe_stage_skid;

    localparam int DATA_W = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                last_pop_edge = 0;
    logic              hold = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    pipe_stage_skid_if #(.DATA_W(DATA_W)) bus1 ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) bus0 ();

    pipe_stage_skid #(.DATA_W(DATA_W), .RST_VAL(40'h0), .SKID(1'b1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .RST_VAL(40'hA5), .SKID(1'b0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int   n;
        logic acc;
        n = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        do begin
            acc = bus1.in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus1.occupancy != 2'd0 && n < 100) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n < 100), 64'd1);
    endtask

    // Scoreboard on the skid build: queue size is the model occupancy.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stable_data", 64'(bus1.out_data), 64'(hold_data));
                check("stable_valid", 64'(bus1.out_valid), 64'd1);
            end
            check("occ_model", 64'(bus1.occupancy), 64'(exp_q.size()));
            check("valid_model", 64'(bus1.out_valid), 64'(exp_q.size() != 0));
            if (bus1.out_valid && bus1.out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("sb_data", 64'(bus1.out_data), 64'(exp_q.pop_front()));
                last_pop_edge = cyc + 1;
            end
            if (bus1.flush) exp_q.delete();
            else if (bus1.in_valid && bus1.in_ready) exp_q.push_back(bus1.in_data);
            hold      = bus1.out_valid && !bus1.out_ready && !bus1.flush;
            hold_data = bus1.out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        bus1.in_valid = 1'b1; bus1.in_data = 40'h00ABCD1234; bus1.flush = 1'b0; bus1.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 40'h00ABCD1234; bus0.flush = 1'b0; bus0.out_ready = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_valid", 64'(bus1.out_valid), 64'd0);
            check("rst_data", 64'(bus1.out_data), 64'd0);
            check("rst_occ", 64'(bus1.occupancy), 64'd0);
            check("rst0_data", 64'(bus0.out_data), 64'hA5);
        end
        rst = 1'b0;
        bus1.in_valid = 1'b0;
        bus0.in_valid = 1'b0;
        check("rst_in_ready", 64'(bus1.in_ready), 64'd1);

        // Single transfer held under backpressure
        send(40'h42);
        bus1.in_valid = 1'b0;
        check("single_valid", 64'(bus1.out_valid), 64'd1);
        check("single_data", 64'(bus1.out_data), 64'h42);
        check("single_occ", 64'(bus1.occupancy), 64'd1);
        repeat (3) step();
        check("single_hold", 64'(bus1.out_data), 64'h42);
        bus1.out_ready = 1'b1;
        step();
        check("single_pop_occ", 64'(bus1.occupancy), 64'd0);
        bus1.out_ready = 1'b0;

        // Fill both entries, third beat held off
        send(40'h11);
        send(40'h22);
        bus1.in_data = 40'h33;
        check("bp_occ2", 64'(bus1.occupancy), 64'd2);
        check("bp_in_ready", 64'(bus1.in_ready), 64'd0);
        step();
        check("bp_occ2_hold", 64'(bus1.occupancy), 64'd2);
        check("bp_head", 64'(bus1.out_data), 64'h11);
        bus1.out_ready = 1'b1;
        k = cyc;
        send(40'h33);
        bus1.in_valid = 1'b0;
        drain();
        check("bp_consecutive", 64'(last_pop_edge - k), 64'd3);

        // Streaming, then streaming with one stalled cycle
        for (int pass = 0; pass < 2; pass++) begin
            bus1.out_ready = 1'b1;
            k = cyc;
            fork
                begin
                    for (int i = 1; i <= 16; i++) send(DATA_W'(i));
                    bus1.in_valid = 1'b0;
                end
                begin
                    if (pass == 1) begin
                        repeat (4) step();
                        bus1.out_ready = 1'b0;
                        step();
                        bus1.out_ready = 1'b1;
                    end
                end
            join
            drain();
            check("stream_cycles", 64'(last_pop_edge - k), 64'(17 + pass));
        end
        bus1.out_ready = 1'b0;

        // Flush at occupancy 2 with a beat presented
        send(40'h55);
        send(40'h66);
        bus1.in_data = 40'h77;
        bus1.flush = 1'b1;
        step();
        bus1.flush = 1'b0;
        bus1.in_valid = 1'b0;
        check("flush2_occ", 64'(bus1.occupancy), 64'd0);
        check("flush2_valid", 64'(bus1.out_valid), 64'd0);
        bus1.out_ready = 1'b1;
        repeat (3) step();
        check("flush2_quiet", 64'(bus1.out_valid), 64'd0);
        bus1.out_ready = 1'b0;

        // Flush at occupancy 1 with a real push discarded
        send(40'h88);
        bus1.in_data = 40'h99;
        bus1.flush = 1'b1;
        check("flush1_push_ok", 64'(bus1.in_ready), 64'd1);
        step();
        bus1.flush = 1'b0;
        bus1.in_valid = 1'b0;
        check("flush1_occ", 64'(bus1.occupancy), 64'd0);
        bus1.out_ready = 1'b1;
        repeat (3) step();
        send(40'hFF_0000_00A5);
        bus1.in_valid = 1'b0;
        drain();
        bus1.out_ready = 1'b0;

        // Reset in the middle of traffic
        send(40'hC1);
        send(40'hC2);
        bus1.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_occ", 64'(bus1.occupancy), 64'd0);
        check("midrst_data", 64'(bus1.out_data), 64'd0);
        check("midrst_valid", 64'(bus1.out_valid), 64'd0);

        // Single-entry build
        bus0.in_valid = 1'b1;
        bus0.in_data = 40'h0101;
        bus0.out_ready = 1'b0;
        step();
        bus0.in_valid = 1'b0;
        check("s0_valid", 64'(bus0.out_valid), 64'd1);
        check("s0_data", 64'(bus0.out_data), 64'h0101);
        check("s0_in_ready_lo", 64'(bus0.in_ready), 64'd0);
        bus0.out_ready = 1'b1;
        #1;
        check("s0_in_ready_comb", 64'(bus0.in_ready), 64'd1);
        bus0.in_valid = 1'b1;
        bus0.in_data = 40'h0202;
        step();
        check("s0_replace_data", 64'(bus0.out_data), 64'h0202);
        check("s0_replace_occ", 64'(bus0.occupancy), 64'd1);
        bus0.out_ready = 1'b0;
        bus0.in_data = 40'h0303;
        step();
        bus0.in_valid = 1'b0;
        check("s0_blocked_data", 64'(bus0.out_data), 64'h0202);
        check("s0_blocked_occ", 64'(bus0.occupancy), 64'd1);

        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It carries an arbitrary packed control+data payload between processor stages (F/D, D/X, X/M, M/W). It adds backpressure (stall), flush (kill) and occupancy reporting, which plain per-bit dff stage registers lack. With SKID=1 it sustains one transfer per cycle while every output is driven directly from a flop.

Parameters:
DATA_W, 40, payload width in bits (e.g. pc+alu_out+reg2data+ctrl).
RST_VAL, 0, value loaded into out_data and the skid entry on reset.
SKID, 1, 1 = 2-entry skid (in_ready registered); 0 = single entry (in_ready = !out_valid | out_ready).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream stage presents a payload
in_ready  output  1  stage can accept; transfer happens when in_valid & in_ready
in_data  input  DATA_W  upstream payload
flush  input  1  kill all held entries (branch mispredict / exception)
out_valid  output  1  out_data holds a live payload
out_ready  input  1  downstream accepts; transfer happens when out_valid & out_ready
out_data  output  DATA_W  payload to downstream stage
occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Reset (edge with rst=1): occupancy=0, out_valid=0, out_data=RST_VAL, skid entry=RST_VAL, in_ready=1 from the following cycle. rst dominates flush and all handshakes.
- push = in_valid & in_ready; pop = out_valid & out_ready, both sampled at the same edge.
- States (SKID=1): EMPTY (occ 0), ONE (main valid), TWO (main + skid valid).
  - EMPTY: push -> ONE, main<=in_data. Otherwise stay.
  - ONE: push & pop -> ONE, main<=in_data. push only -> TWO, skid<=in_data. pop only -> EMPTY. Neither -> stay.
  - TWO: in_ready=0, so no push. pop -> ONE, main<=skid. Otherwise stay.
- SKID=1: in_ready = (occupancy != 2), driven from a register with no combinational path from out_ready.
- SKID=0: the TWO state is unreachable. in_ready = !out_valid | out_ready (combinational). ONE with push & pop reloads main.
- out_valid = (occupancy != 0). out_data always presents the main entry.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when the stage was EMPTY, or when it was ONE and popped in the same cycle.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change (except on flush/rst).
- Ordering: strictly FIFO. The skid entry is never presented ahead of main.
- Flush (edge with flush=1, rst=0): next state EMPTY, occupancy=0, out_valid=0.
  - A push in the same cycle counts as accepted, but its payload is discarded.
  - A pop in the same cycle counts as consumed by downstream.
  - out_data retains its previous value; it is don't-care while out_valid=0.
- Throughput: SKID=1 sustains 1 transfer/cycle under continuous in_valid & out_ready. A single-cycle out_ready deassertion loses no data and no cycle beyond the stall.
- Width: all payload handling is bit-exact for any DATA_W >= 1. No truncation or extension.
- Reset mid-operation discards held entries identically to flush, and additionally restores RST_VAL.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=0x00ABCD1234 -> out_valid=0, out_data=0, occupancy=0 throughout. in_ready=1 the cycle after rst drops.
- Single transfer: EMPTY, push 0x0000000042 with out_ready=0 -> next cycle out_valid=1, out_data=0x42, occupancy=1. Held stable 3 cycles. Raise out_ready -> occupancy=0 after 1 edge.
- Backpressure (SKID=1): out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0, C=0x33 held off. Raise out_ready -> outputs A, B, C on consecutive cycles, no loss or duplication.
- Streaming: 16 back-to-back pushes 0x01..0x10 with out_ready=1 -> 16 pops in order, one per cycle. With out_ready low for cycle 5 only -> same sequence, one extra cycle total.
- Flush: occupancy=2 (0x55, 0x66), assert flush for 1 cycle with simultaneous push of 0x77 -> occupancy=0, out_valid=0 next cycle. 0x55, 0x66 and 0x77 never appear at the output.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, push+pop replaces main, occupancy stays 1.
